aes_round_engine: RTL and testbench

Iterative AES-128 encryption core with a parametrised round count; successor to the single-round `aes` step block. It accepts one plaintext/key pair per handshake, computes one full AES round per clock with round keys expanded on the fly, and presents the ciphertext behind a valid/ready output handshake. It sits between the plaintext source and the ciphertext sink of the crypto datapath.

---
 rtl/aes_pkg.sv | 93 +++++++++
 rtl/aes_key_step.sv | 28 ++
 rtl/aes_round_engine.sv | 95 +++++++++
 tb/tb_aes_round_engine.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared types and combinational AES helpers for aes_round_engine.
//   aes_fsm_t   : engine control states (IDLE, RUN, DONE)
//   sbox        : AES S-box lookup (256-entry table)
//   xtime, rcon : GF(2^8) doubling (poly 0x11b) and key-schedule round constants
//   sub_bytes, shift_rows, mix_columns : 128-bit state transforms.
// Byte k of a 128-bit block is bits [127-8k -: 8], at row k%4, column k/4.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_fsm_t;

  // Row-major S-box: entry i is at bits [2047-8i -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for round r (1..10); 0 outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*(((c+r)%4))+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one step of the AES-128 key schedule, purely combinational.
//   rk      : current round key (w0..w3, w0 in the top 32 bits)
//   rcon    : round constant for the round being produced
//   rk_next : next round key
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);

  logic [31:0] w0, w1, w2, w3, rot, sub;
  logic [31:0] n0, n1, n2, n3;

  assign w0  = rk[127:96];
  assign w1  = rk[95:64];
  assign w2  = rk[63:32];
  assign w3  = rk[31:0];
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign n0  = w0 ^ sub ^ {rcon, 24'h000000};
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128 encryptor, one full round per clock,
// round keys expanded on the fly. NR rounds (1..10); the last round skips
// MixColumns, so NR=10 is standard AES-128.
//   clk, rst (async, active-low)
//   in_valid/in_ready  : plaintext (matrix1) + key (matrix2) handshake
//   out_valid/out_ready: ciphertext (matrix3) handshake; matrix3 shows the
//                        running state while busy
//   round              : rounds completed in the state register (0..NR)
// Optional macro AES_TRACE_EN adds trace_valid / trace_state, a one-cycle
// pulse after every state-register update (NR+1 per block).
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] matrix1,
  input  logic [127:0] matrix2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] matrix3,
  output logic [3:0]   round
`ifdef AES_TRACE_EN
  ,
  output logic         trace_valid,
  output logic [127:0] trace_state
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NR - 1);

  aes_fsm_t     fsm_q;
  logic [127:0] state_q, rk_q, rk_next, sr_w, round_out;
  logic [3:0]   round_q;
  logic         last_w;

  aes_key_step u_key_step (
    .rk      (rk_q),
    .rcon    (rcon(round_q + 4'd1)),
    .rk_next (rk_next)
  );

  assign last_w    = (round_q == LAST_IDX);
  assign sr_w      = shift_rows(sub_bytes(state_q));
  assign round_out = (last_w ? sr_w : mix_columns(sr_w)) ^ rk_next;

  // rst is part of in_ready so the engine never advertises space in reset.
  assign in_ready  = (fsm_q == IDLE) && rst;
  assign out_valid = (fsm_q == DONE);
  assign matrix3   = state_q;
  assign round     = round_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      round_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: if (in_valid) begin
          state_q <= matrix1 ^ matrix2;
          rk_q    <= matrix2;
          round_q <= '0;
          fsm_q   <= RUN;
        end
        RUN: begin
          rk_q    <= rk_next;
          state_q <= round_out;
          round_q <= round_q + 4'd1;
          if (last_w) fsm_q <= DONE;
        end
        DONE: if (out_ready) fsm_q <= IDLE;
        default: fsm_q <= IDLE;
      endcase
    end
  end

`ifdef AES_TRACE_EN
  logic trace_valid_q;

  // Pulse follows every state update: the accept edge and each RUN edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) trace_valid_q <= 1'b0;
    else      trace_valid_q <= ((fsm_q == IDLE) && in_valid) || (fsm_q == RUN);
  end

  assign trace_valid = trace_valid_q;
  assign trace_state = state_q;
`endif

endmodule

// File: tb/tb_aes_round_engine.sv
module tb_aes_round_engine;
  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] matrix1 = '0;
  logic [127:0] matrix2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] matrix3;
  logic [3:0]   round;
`ifdef AES_TRACE_EN
  logic         trace_valid;
  logic [127:0] trace_state;
`endif

  aes_round_engine #(.NR(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .matrix1   (matrix1),
    .matrix2   (matrix2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .matrix3   (matrix3),
    .round     (round)
`ifdef AES_TRACE_EN
    ,
    .trace_valid (trace_valid),
    .trace_state (trace_state)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rand_mode = 1'b0;
  bit or_manual = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Single driver of out_ready; lands after the main process's #1 updates.
  always @(posedge clk) begin
    #2;
    out_ready = rand_mode ? ($urandom_range(0, 2) != 0) : or_manual;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (independent of the RTL) ----------------
  logic [7:0]   sb [256];
  logic [127:0] mdl [0:10];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Fills mdl[r] with the state after r rounds (full key expansion up front).
  task automatic run_model(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [0:43];
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] blk;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    blk = pt ^ {w[0], w[1], w[2], w[3]};
    mdl[0] = blk;
    for (int r = 1; r <= NR; r++) begin
      for (int k = 0; k < 16; k++) b[k] = sb[blk[127-8*k -: 8]];
      for (int k = 0; k < 16; k++) t[k] = b[4*(((k/4) + (k%4)) % 4) + (k%4)];
      for (int c = 0; c < 4; c++) begin
        if (r < NR) begin
          b[4*c+0] = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          b[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
          b[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
          b[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
        end else begin
          for (int j = 0; j < 4; j++) b[4*c+j] = t[4*c+j];
        end
      end
      for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = b[k];
      blk = blk ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      mdl[r] = blk;
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  int           mode = 0;      // 0: engine should be idle, 1: a block is in flight
  int           m_e0 = 0;
  int           prev_e0 = 0;
  bit           have_prev = 1'b0;
  logic [127:0] m_st [0:10];
  logic [127:0] m_last = '0;
  logic [3:0]   m_lastr = '0;

  always @(negedge clk) begin : cmp
    int           k, kc;
    logic [127:0] e_m3;
    logic [3:0]   e_rnd;
    logic         e_ov, e_ir, e_tv;
    if (!rst) begin
      check("rst_matrix3", matrix3, '0);
      check("rst_round", 128'(round), '0);
      check("rst_out_valid", 128'(out_valid), '0);
      check("rst_in_ready", 128'(in_ready), '0);
`ifdef AES_TRACE_EN
      check("rst_trace_valid", 128'(trace_valid), '0);
`endif
      mode = 0; m_last = '0; m_lastr = '0; have_prev = 1'b0;
    end else begin
      k = cyc - m_e0;
      kc = (k > NR) ? NR : k;
      if (mode == 1) begin
        e_m3 = m_st[kc]; e_rnd = 4'(kc); e_ov = (k >= NR); e_ir = 1'b0; e_tv = (k <= NR);
      end else begin
        e_m3 = m_last; e_rnd = m_lastr; e_ov = 1'b0; e_ir = 1'b1; e_tv = 1'b0;
      end
      check("matrix3", matrix3, e_m3);
      check("round", 128'(round), 128'(e_rnd));
      check("out_valid", 128'(out_valid), 128'(e_ov));
      check("in_ready", 128'(in_ready), 128'(e_ir));
`ifdef AES_TRACE_EN
      check("trace_valid", 128'(trace_valid), 128'(e_tv));
      check("trace_state", trace_state, e_m3);
`else
      if (e_tv) begin end
`endif
      // Predict what the coming rising edge does.
      if (mode == 0 && in_valid) begin
        run_model(matrix1, matrix2);
        for (int r = 0; r <= NR; r++) m_st[r] = mdl[r];
        m_e0 = cyc + 1;
        if (have_prev) check("accept_spacing", 128'((m_e0 - prev_e0) >= NR + 2), 128'(1));
        prev_e0 = m_e0; have_prev = 1'b1;
        mode = 1;
      end else if (mode == 1 && k >= NR && out_ready) begin
        m_last = m_st[NR]; m_lastr = 4'(NR);
        mode = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] pt, input logic [127:0] key, output int acc);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; matrix1 = pt; matrix2 = key;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", n);
    end
    acc = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    matrix1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    matrix2 = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_valid(output int c);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: still 0 after %0d cycles", n);
    end
    c = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL idle_timeout: in_ready still 0 after %0d cycles", n);
    end
  endtask

  initial begin
    int acc, c, n;
    build_sbox();
    // Pin the model to published vectors.
    run_model(B_PT, B_KEY);
    check("model_B_round0", mdl[0], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("model_B_round1", mdl[1], 128'ha49c7ff2689f352b6b5bea43026a5049);
    check("model_B_ct", mdl[NR], B_CT);
    run_model(C_PT, C_KEY);
    check("model_C_ct", mdl[NR], C_CT);

    // Reset
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 128'(in_ready), 128'(1));

    // App. B with latency
    or_manual = 1'b1;
    send(B_PT, B_KEY, acc);
    wait_valid(c);
    check("B_latency", 128'(c - acc), 128'(NR));
    check("B_ct", matrix3, B_CT);
    check("B_round", 128'(round), 128'(NR));
    wait_idle();

    // App. C.1
    send(C_PT, C_KEY, acc);
    wait_valid(c);
    check("C_ct", matrix3, C_CT);
    wait_idle();

`ifdef AES_TRACE_EN
    begin
      int pulses = 0;
      send(B_PT, B_KEY, acc);
      for (int i = 0; i < NR + 5; i++) begin
        @(negedge clk);
        if (trace_valid) begin
          pulses++;
          if (round == 4'd0) check("trace_r0", trace_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
          if (round == 4'd1) check("trace_r1", trace_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
        end
      end
      check("trace_pulses", 128'(pulses), 128'(NR + 1));
      wait_idle();
    end
`endif

    // Backpressure: hold out_ready low, poke in_valid meanwhile
    or_manual = 1'b0;
    send(B_PT, B_KEY, acc);
    wait_valid(c);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      matrix1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      matrix2 = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_matrix3", matrix3, B_CT);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; or_manual = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_in_ready", 128'(in_ready), 128'(1));
    check("bp_idle_out_valid", 128'(out_valid), 128'(0));

    // Reset in the middle of a block
    send(B_PT, B_KEY, acc);
    n = 0;
    @(negedge clk);
    while (round != 4'd5 && n < 20) begin @(negedge clk); n++; end
    check("reached_round5", 128'(round), 128'(5));
    #1 rst = 1'b0;
    #1;
    check("abort_matrix3", matrix3, '0);
    check("abort_round", 128'(round), '0);
    check("abort_out_valid", 128'(out_valid), '0);
    check("abort_in_ready", 128'(in_ready), '0);
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;
    send(B_PT, B_KEY, acc);
    wait_valid(c);
    check("after_abort_ct", matrix3, B_CT);
    wait_idle();

    // Back-to-back random blocks with random sink stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 100; i++)
      send({$urandom(), $urandom(), $urandom(), $urandom()},
           {$urandom(), $urandom(), $urandom(), $urandom()}, acc);
    wait_idle();
    rand_mode = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
